fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small instruction queue between the fetch stage and decode.
- Buffers {pc, inst} pairs produced by fetch.
- Uses valid/ready handshakes on both sides, so decode stalls do not drop instructions.
- A flush input discards all buffered entries when a taken branch redirects fetch.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of pc and instruction fields.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous discard of all entries (taken branch).
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  pc of the incoming instruction.
- in_inst  input  XLEN  incoming instruction word.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_inst  output  XLEN  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset: rst==0 at posedge clears wr_ptr, rd_ptr and count to 0.
  - After reset: out_valid=0, out_pc=0, out_inst=NOP_INST (32'h00000013), in_ready=1.
  - Reset has priority over flush and handshakes.
- Push: occurs when in_valid && in_ready at posedge.
  - Writes {in_pc, in_inst} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready at posedge.
  - rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH).
  - No push is accepted while full, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
  - out_pc/out_inst show the entry at rd_ptr combinationally from storage.
  - When empty: out_pc=0, out_inst=NOP_INST.
- Count updates:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, both pointers advance.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N, i.e. one cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Fullness is taken from count, not from pointer comparison.
- Flush: when flush=1 at posedge (rst=1), pointers and count go to 0.
  - A push or pop in the same cycle is ignored; the in-flight instruction is dropped.
  - Storage contents are left unchanged; they are don't-care.
- Empty pop (out_ready=1, count=0): no effect.
- Full push attempt (in_valid=1, count=DEPTH): no write, in_ready=0. Fetch holds its data.
- Input data is sampled only on an accepted push. out_* remain stable while out_valid && !out_ready.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when count==0 && in_valid && !flush, the input passes through combinationally.
  - out_valid=1, out_pc=in_pc, out_inst=in_inst in the same cycle.
  - If out_ready=1, the entry is consumed without being written; count stays 0.
  - If out_ready=0, it is pushed normally.
  - flush=1 masks the bypass, so out_valid=0 that cycle.
- Undefined: no combinational input-to-output path; minimum latency is 1 cycle as above.

Decomposition:
- Package fetch_pkg:
  - XLEN localparam (32).
  - NOP_INST constant 32'h00000013.
  - typedef fetch_entry_t = struct {pc, inst}.
  - Shared by fetch, fetch_queue and decode.
- Sub-module fetchq_mem: DEPTH x fetch_entry_t register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, out_inst=32'h00000013, in_ready=1.
- Fill: push pc 0,4,8,12 with inst 32'h00500113, 32'h00210233, ... and out_ready=0 -> count=4, in_ready=0. A 5th push is refused; head stays pc=0.
- Drain and wrap: from full, pop one and then push pc=16 on the next cycle -> order of out_pc is 4,8,12,16 with wr_ptr wrapped. Then count returns to 0 and out_valid=0.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2 and pcs exit in order with no loss or duplication.
- Flush: count=3 with flush=1 and in_valid=1 (pc=40) on the same edge -> count=0 next cycle and pc=40 never appears on out_pc.
- Bypass (FETCHQ_BYPASS_EN): empty queue, in_valid=1, pc=20, out_ready=1 -> out_valid=1 and out_pc=20 in the same cycle, count stays 0. Repeat with flush=1 -> out_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Types and constants shared by fetch, fetch_queue and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0), driven on an empty queue output.
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetchq_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetchq_mem
// Description : DEPTH x fetch_entry_t register array, one synchronous write
//               port and one asynchronous read port. No reset: contents are
//               only meaningful where the queue pointers say they are.
// Revision    : 1.0 - initial release
// ============================================================================
module fetchq_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem [DEPTH];

    // Write the entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction queue between fetch and decode. Buffers {pc, inst}
//               pairs with valid/ready on both sides; flush drops everything.
//               Optional macro FETCHQ_BYPASS_EN adds a combinational
//               input-to-output path when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          mem_we;
    fetch_entry_t  wdata;
    fetch_entry_t  rdata;

    assign empty    = (occ == '0);
    assign in_ready = (occ != FULL_COUNT);
    assign count    = occ;

`ifdef FETCHQ_BYPASS_EN
    // An empty queue hands a fresh fetch straight to decode; flush masks it.
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle is never stored.
    assign push   = in_valid && in_ready && !(bypass && out_ready);
    assign pop    = !empty && out_ready;
    assign mem_we = rst && !flush && push;

    assign wdata.pc   = in_pc;
    assign wdata.inst = in_inst;

    fetchq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Head presentation: stored entry, else bypassed input, else NOP.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = NOP_INST;
        if (!empty) begin
            out_valid = 1'b1;
            out_pc    = rdata.pc;
            out_inst  = rdata.inst;
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    // Pointer and occupancy update; reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: directed vector table,
//               hand-written corner sequences, random traffic vs. a queue
//               model. Honours FETCHQ_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of {pc, inst} pairs.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t mq[$];

    // Outputs sampled before the edge, and model expectations for the same instant.
    logic        s_valid, s_ready;
    logic [31:0] s_pc, s_inst;
    logic [2:0]  s_count;
    logic        m_valid, m_ready;
    logic [31:0] m_pc, m_inst;
    logic [2:0]  m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, sample outputs before the edge, advance the model.
    task automatic cyc(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy);
        bit byp, full, pop_q, push_q;
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
        #1;
        s_valid = out_valid; s_ready = in_ready; s_pc = out_pc; s_inst = out_inst; s_count = count;
        byp = BYP && (mq.size() == 0) && iv && !f;
        m_count = 3'(mq.size());
        m_ready = (mq.size() != DEPTH);
        if (mq.size() > 0) begin
            m_valid = 1'b1; m_pc = mq[0].pc; m_inst = mq[0].inst;
        end else if (byp) begin
            m_valid = 1'b1; m_pc = pc; m_inst = inst;
        end else begin
            m_valid = 1'b0; m_pc = 32'h0; m_inst = NOP;
        end
        @(posedge clk);
        if (!r || f) begin
            mq.delete();
        end else if (!(byp && ordy)) begin
            full   = (mq.size() == DEPTH);
            pop_q  = (mq.size() > 0) && ordy;
            push_q = iv && !full;
            if (pop_q)  void'(mq.pop_front());
            if (push_q) mq.push_back('{pc, inst});
        end
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, 64'(s_valid), 64'(m_valid));
        chk({tag, ".in_ready"},  64'(s_ready), 64'(m_ready));
        chk({tag, ".count"},     64'(s_count), 64'(m_count));
        if (m_valid) begin
            chk({tag, ".out_pc"},   64'(s_pc),   64'(m_pc));
            chk({tag, ".out_inst"}, 64'(s_inst), 64'(m_inst));
        end else begin
            chk({tag, ".empty_pc"},   64'(s_pc),   64'h0);
            chk({tag, ".empty_inst"}, 64'(s_inst), 64'(NOP));
        end
    endtask

    typedef struct {
        logic        r, f, iv;
        logic [31:0] pc, inst;
        logic        ordy, do_chk;
        logic        ev;
        logic [31:0] epc, einst;
        logic        eir;
        logic [2:0]  ecnt;
    } vec_t;

    localparam logic [31:0] I0 = 32'h00500113, I1 = 32'h00210233, I2 = 32'h00308193,
                            I3 = 32'h40110133, I4 = 32'h00c00293;

    vec_t tbl[16];

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset, fill to full, refused 5th push, pop/push wrap, drain to empty.
        //           r  f  iv pc   inst  ordy chk ev   epc  einst             eir  cnt
        tbl[0]  = '{0, 0, 1, 100, I0,   0,   0,  0,   0,   NOP,              1,   0};
        tbl[1]  = '{0, 0, 1, 100, I0,   0,   0,  0,   0,   NOP,              1,   0};
        tbl[2]  = '{1, 0, 0, 0,   0,    0,   1,  0,   0,   NOP,              1,   0};
        tbl[3]  = '{1, 0, 1, 0,   I0,   0,   1,  BYP, 0,   BYP ? I0 : NOP,   1,   0};
        tbl[4]  = '{1, 0, 1, 4,   I1,   0,   1,  1,   0,   I0,               1,   1};
        tbl[5]  = '{1, 0, 1, 8,   I2,   0,   1,  1,   0,   I0,               1,   2};
        tbl[6]  = '{1, 0, 1, 12,  I3,   0,   1,  1,   0,   I0,               1,   3};
        tbl[7]  = '{1, 0, 1, 20,  I4,   0,   1,  1,   0,   I0,               0,   4};
        tbl[8]  = '{1, 0, 1, 20,  I4,   1,   1,  1,   0,   I0,               0,   4};
        tbl[9]  = '{1, 0, 1, 16,  I4,   0,   1,  1,   4,   I1,               1,   3};
        tbl[10] = '{1, 0, 0, 0,   0,    1,   1,  1,   4,   I1,               0,   4};
        tbl[11] = '{1, 0, 0, 0,   0,    1,   1,  1,   8,   I2,               1,   3};
        tbl[12] = '{1, 0, 0, 0,   0,    1,   1,  1,   12,  I3,               1,   2};
        tbl[13] = '{1, 0, 0, 0,   0,    1,   1,  1,   16,  I4,               1,   1};
        tbl[14] = '{1, 0, 0, 0,   0,    1,   1,  0,   0,   NOP,              1,   0};
        tbl[15] = '{1, 0, 0, 0,   0,    0,   1,  0,   0,   NOP,              1,   0};

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy);
            if (tbl[i].do_chk) begin
                chk($sformatf("vec%0d.out_valid", i), 64'(s_valid), 64'(tbl[i].ev));
                chk($sformatf("vec%0d.out_pc", i),    64'(s_pc),    64'(tbl[i].epc));
                chk($sformatf("vec%0d.out_inst", i),  64'(s_inst),  64'(tbl[i].einst));
                chk($sformatf("vec%0d.in_ready", i),  64'(s_ready), 64'(tbl[i].eir));
                chk($sformatf("vec%0d.count", i),     64'(s_count), 64'(tbl[i].ecnt));
            end
        end

        // Simultaneous push/pop at count=2 for 10 cycles: occupancy steady, order kept.
        cyc(1, 0, 1, 200, 32'h1000, 0);
        cyc(1, 0, 1, 204, 32'h1001, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 1, 32'(208 + 4 * k), 32'(32'h1002 + k), 1);
            chk($sformatf("steady%0d.count", k),  64'(s_count), 64'd2);
            chk($sformatf("steady%0d.out_pc", k), 64'(s_pc), 64'(200 + 4 * k));
        end
        cyc(1, 0, 0, 0, 0, 1);
        chk("steady_tail0.out_pc", 64'(s_pc), 64'd240);
        cyc(1, 0, 0, 0, 0, 1);
        chk("steady_tail1.out_pc", 64'(s_pc), 64'd244);
        cyc(1, 0, 0, 0, 0, 0);
        chk("steady_end.count", 64'(s_count), 64'd0);

        // Flush at count=3 with a concurrent push of pc=40: the push is dropped.
        cyc(1, 0, 1, 28, 32'h2000, 0);
        cyc(1, 0, 1, 32, 32'h2001, 0);
        cyc(1, 0, 1, 36, 32'h2002, 0);
        cyc(1, 1, 1, 40, 32'h2003, 0);
        chk("flush_pre.count", 64'(s_count), 64'd3);
        cyc(1, 0, 0, 0, 0, 0);
        chk("flush_post.count",     64'(s_count), 64'd0);
        chk("flush_post.out_valid", 64'(s_valid), 64'd0);
        cyc(1, 0, 1, 44, 32'h2004, 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("flush_next.out_pc", 64'(s_pc),    64'd44);
        chk("flush_next.count",  64'(s_count), 64'd1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("flush_drained.count", 64'(s_count), 64'd0);

`ifdef FETCHQ_BYPASS_EN
        // Bypass: empty queue passes input straight through; flush masks it.
        cyc(1, 0, 1, 20, 32'h3000, 1);
        chk("byp.out_valid", 64'(s_valid), 64'd1);
        chk("byp.out_pc",    64'(s_pc),    64'd20);
        cyc(1, 0, 0, 0, 0, 0);
        chk("byp_after.count", 64'(s_count), 64'd0);
        cyc(1, 1, 1, 20, 32'h3000, 1);
        chk("byp_flush.out_valid", 64'(s_valid), 64'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("byp_flush_after.count", 64'(s_count), 64'd0);
`endif

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 2) != 0));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
